branch_resolve_queue: RTL and testbench
=======================================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of in-flight branch entries (power of two, 2..32).
REQ-002 The block SHALL have parameter GHR_W, default 12, meaning the width of the global history snapshot.
REQ-003 clock  in  1  the single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
REQ-005 pred_valid  in  1  a new prediction is issued this cycle.
REQ-006 pred_ready  out  1  queue can accept a prediction (not full).
REQ-007 pred_pc  in  32  PC of the predicted branch.
REQ-008 pred_taken  in  1  final tournament prediction.
REQ-009 pred_global  in  1  global-component prediction.
REQ-010 pred_local  in  1  local-component prediction.
REQ-011 pred_ghr  in  GHR_W  global history at prediction time.
REQ-012 res_valid  in  1  execute stage resolves the oldest branch this cycle.
REQ-013 res_ready  out  1  queue holds at least one entry (not empty).
REQ-014 res_taken  in  1  actual branch outcome.
REQ-015 flush_in  in  1  external pipeline flush; discards all entries.
REQ-016 upd_valid  out  1  registered predictor-update pulse.
REQ-017 upd_pc, upd_ghr, upd_taken  out  32/GHR_W/1  PC, history snapshot and actual outcome of the resolved branch.
REQ-018 upd_mispredict  out  1  final prediction differed from the outcome.
REQ-019 upd_choice_inc / upd_choice_dec  out  1/1  move the choice counter toward global / toward local.
REQ-020 redirect  out  1  one-cycle pulse requesting a front-end redirect; coincident with upd_valid && upd_mispredict.
REQ-021 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-022 mispred_count  out  16  total mispredictions since reset, wrapping modulo 2^16.

Function
REQ-023 Storage SHALL be a circular FIFO with head/tail pointers; pred_ready = (count != DEPTH); res_ready = (count != 0).
REQ-024 A push SHALL occur when pred_valid && pred_ready and no flush condition (REQ-030, REQ-031) is active in the same cycle.
REQ-025 A pop SHALL occur when res_valid && res_ready && !flush_in; res_valid while empty SHALL be ignored, with no update emitted.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push while full SHALL be refused even if a pop occurs that cycle.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 On a pop, the update outputs SHALL be registered and valid exactly one cycle later for one cycle: upd_mispredict = (pred_taken != res_taken).
REQ-029 upd_choice_inc = (pred_global==res_taken) && (pred_local!=res_taken); upd_choice_dec = (pred_local==res_taken) && (pred_global!=res_taken); both SHALL be 0 when the components agree in correctness.
REQ-030 A pop with mispredict SHALL discard all remaining entries on the same edge (count becomes 0) and SHALL drop any push in that cycle.
REQ-031 flush_in SHALL clear the queue on the same edge, override push and pop, and emit no update.
REQ-032 mispred_count SHALL increment on the edge that registers a mispredicting update.
REQ-033 When no pop occurred in the prior cycle, upd_valid, upd_mispredict, upd_choice_inc/dec and redirect SHALL be 0; payload outputs hold their last values.

Reset
REQ-034 While reset==0: head, tail and count = 0; upd_valid, upd_mispredict, upd_choice_inc, upd_choice_dec, redirect = 0; upd_pc, upd_ghr, upd_taken = 0; mispred_count = 0; pred_ready = 1; res_ready = 0.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately, and no update pulse SHALL be produced for them after release.
REQ-036 Storage array contents need not be reset.

Verification
REQ-037 Push PC 0x100, pred_taken=1 (global=1, local=0); resolve res_taken=1 -> next cycle upd_valid=1, upd_pc=0x100, upd_mispredict=0, upd_choice_inc=1, redirect=0.
REQ-038 Push 8 entries with DEPTH=8 -> pred_ready=0, count=8; 9th push refused; push+pop same cycle while full -> count=7 after the edge, push dropped.
REQ-039 Push A, B, C; resolve A mispredicted -> redirect=1, mispred_count=1, count=0; a push issued in the same cycle is not stored.
REQ-040 Push 3 entries, assert flush_in together with res_valid -> count=0, no upd_valid in the following cycle.
REQ-041 Ten push/pop pairs across pointer wrap with DEPTH=8 -> updates emerge in order with matching PC/GHR; res_valid while empty -> no upd_valid.
REQ-042 Assert reset with count=5 -> count=0, pred_ready=1 immediately; after release, no update pulses appear.

Source files
------------

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: prediction/resolution/update bundle for the branch resolve queue
// Ports (signals): pred_* push side, res_*/flush_in pop side, upd_*/redirect registered
//   predictor update, count occupancy, mispred_count running mispredict total.
//   master = driver of predictions/resolutions, slave = the queue.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 8,
    parameter int GHR_W = 12
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic             pred_valid;
    logic             pred_ready;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             pred_global;
    logic             pred_local;
    logic [GHR_W-1:0] pred_ghr;
    logic             res_valid;
    logic             res_ready;
    logic             res_taken;
    logic             flush_in;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             upd_mispredict;
    logic             upd_choice_inc;
    logic             upd_choice_dec;
    logic             redirect;
    logic [CW-1:0]    count;
    logic [15:0]      mispred_count;
    modport master (
        output pred_valid, pred_pc, pred_taken, pred_global, pred_local, pred_ghr,
        output res_valid, res_taken, flush_in,
        input  pred_ready, res_ready, upd_valid, upd_pc, upd_ghr, upd_taken,
        input  upd_mispredict, upd_choice_inc, upd_choice_dec, redirect, count, mispred_count
    );
    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_global, pred_local, pred_ghr,
        input  res_valid, res_taken, flush_in,
        output pred_ready, res_ready, upd_valid, upd_pc, upd_ghr, upd_taken,
        output upd_mispredict, upd_choice_inc, upd_choice_dec, redirect, count, mispred_count
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-flight branch FIFO turning in-order resolutions into predictor updates
// Ports: i_clk clock, i_rst_n async active-low reset,
//   bus (slave modport) carrying prediction push, resolution pop, flush,
//   registered update/redirect outputs, occupancy and mispredict count.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int GHR_W = 12
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    branch_resolve_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [31:0]      r_pc    [DEPTH];
    logic [GHR_W-1:0] r_ghr   [DEPTH];
    logic             r_taken [DEPTH];
    logic             r_glob  [DEPTH];
    logic             r_loc   [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [15:0]      r_mis_cnt;
    logic             r_upd_valid;
    logic [31:0]      r_upd_pc;
    logic [GHR_W-1:0] r_upd_ghr;
    logic             r_upd_taken;
    logic             r_upd_mis;
    logic             r_upd_inc;
    logic             r_upd_dec;
    logic             r_redirect;
    logic             w_pop;
    logic             w_mis;
    logic             w_push;
    logic             w_g_ok;
    logic             w_l_ok;
    assign w_pop  = bus.res_valid && (r_count != '0) && !bus.flush_in;
    assign w_mis  = w_pop && (r_taken[r_head] != bus.res_taken);
    // a mispredicting pop squashes everything younger, including this cycle's push
    assign w_push = bus.pred_valid && (r_count != FULL) && !bus.flush_in && !w_mis;
    assign w_g_ok = r_glob[r_head] == bus.res_taken;
    assign w_l_ok = r_loc[r_head] == bus.res_taken;
    assign bus.pred_ready     = r_count != FULL;
    assign bus.res_ready      = r_count != '0;
    assign bus.count          = r_count;
    assign bus.mispred_count  = r_mis_cnt;
    assign bus.upd_valid      = r_upd_valid;
    assign bus.upd_pc         = r_upd_pc;
    assign bus.upd_ghr        = r_upd_ghr;
    assign bus.upd_taken      = r_upd_taken;
    assign bus.upd_mispredict = r_upd_mis;
    assign bus.upd_choice_inc = r_upd_inc;
    assign bus.upd_choice_dec = r_upd_dec;
    assign bus.redirect       = r_redirect;
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc[r_tail]    <= bus.pred_pc;
            r_ghr[r_tail]   <= bus.pred_ghr;
            r_taken[r_tail] <= bus.pred_taken;
            r_glob[r_tail]  <= bus.pred_global;
            r_loc[r_tail]   <= bus.pred_local;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_mis_cnt   <= '0;
            r_upd_valid <= 1'b0;
            r_upd_pc    <= '0;
            r_upd_ghr   <= '0;
            r_upd_taken <= 1'b0;
            r_upd_mis   <= 1'b0;
            r_upd_inc   <= 1'b0;
            r_upd_dec   <= 1'b0;
            r_redirect  <= 1'b0;
        end else begin
            if (bus.flush_in || w_mis) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= w_pop ? r_head + 1'b1 : r_head;
                r_tail  <= w_push ? r_tail + 1'b1 : r_tail;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            if (w_pop) begin
                r_upd_pc    <= r_pc[r_head];
                r_upd_ghr   <= r_ghr[r_head];
                r_upd_taken <= bus.res_taken;
            end
            r_upd_valid <= w_pop;
            r_upd_mis   <= w_mis;
            r_redirect  <= w_mis;
            r_upd_inc   <= w_pop && w_g_ok && !w_l_ok;
            r_upd_dec   <= w_pop && w_l_ok && !w_g_ok;
            r_mis_cnt   <= r_mis_cnt + 16'(w_mis);
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench with a queue-based reference model
module tb_branch_resolve_queue;
    localparam int DEPTH = 8;
    localparam int GHR_W = 12;
    typedef struct {
        logic [31:0]      pc;
        logic [GHR_W-1:0] ghr;
        logic             t;
        logic             g;
        logic             l;
    } ent_t;
    typedef struct {
        logic [31:0]      pc;
        logic [GHR_W-1:0] ghr;
        logic             t;
        logic             mis;
        logic             inc;
        logic             dec;
        logic [15:0]      mc;
    } upd_t;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   mc;
    ent_t mq[$];
    upd_t eq[$];
    branch_resolve_queue_if #(.DEPTH(DEPTH), .GHR_W(GHR_W)) b ();
    branch_resolve_queue #(.DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (b)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // one cycle: drive inputs, advance the model by the rules, check occupancy after the edge
    task automatic step(input logic pv, input logic [31:0] pc, input logic pt, input logic pg,
                        input logic pl, input logic [GHR_W-1:0] ghr, input logic rv,
                        input logic rt, input logic fl);
        ent_t e;
        logic pop;
        logic mis;
        logic push;
        b.pred_valid  = pv;
        b.pred_pc     = pc;
        b.pred_taken  = pt;
        b.pred_global = pg;
        b.pred_local  = pl;
        b.pred_ghr    = ghr;
        b.res_valid   = rv;
        b.res_taken   = rt;
        b.flush_in    = fl;
        chk("pred_ready", 32'(b.pred_ready), 32'(mq.size() != DEPTH));
        chk("res_ready", 32'(b.res_ready), 32'(mq.size() != 0));
        pop  = rv && mq.size() != 0 && !fl;
        mis  = pop && (mq[0].t != rt);
        push = pv && mq.size() != DEPTH && !fl && !mis;
        if (pop) begin
            e = mq.pop_front();
            if (mis) mc = (mc + 1) % 65536;
            eq.push_back('{e.pc, e.ghr, rt, mis, (e.g == rt) && (e.l != rt),
                           (e.l == rt) && (e.g != rt), 16'(mc)});
        end
        if (fl || mis) mq.delete();
        if (push) mq.push_back('{pc, ghr, pt, pg, pl});
        @(posedge clk);
        #1;
        chk("count", 32'(b.count), 32'(mq.size()));
    endtask
    task automatic push(input logic [31:0] pc, input logic pt, input logic pg, input logic pl,
                        input logic [GHR_W-1:0] ghr);
        step(1'b1, pc, pt, pg, pl, ghr, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic pop(input logic rt);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b1, rt, 1'b0);
    endtask
    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_reset();
        b.pred_valid = 1'b0;
        b.res_valid  = 1'b0;
        b.flush_in   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(b.count), 32'h0);
        chk("rst_pred_ready", 32'(b.pred_ready), 32'h1);
        chk("rst_res_ready", 32'(b.res_ready), 32'h0);
        chk("rst_upd_valid", 32'(b.upd_valid), 32'h0);
        chk("rst_pulses", 32'({b.redirect, b.upd_mispredict, b.upd_choice_inc, b.upd_choice_dec}), 32'h0);
        chk("rst_payload", 32'(b.upd_pc) | 32'(b.upd_ghr) | 32'(b.upd_taken), 32'h0);
        chk("rst_mispred_count", 32'(b.mispred_count), 32'h0);
        mq.delete();
        mc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask
    initial begin : monitor
        upd_t u;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (b.upd_valid) begin
                    if (eq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL upd_unexpected: got upd_valid=1 expected no update");
                    end else begin
                        u = eq.pop_front();
                        chk("upd_pc", b.upd_pc, u.pc);
                        chk("upd_ghr", 32'(b.upd_ghr), 32'(u.ghr));
                        chk("upd_taken", 32'(b.upd_taken), 32'(u.t));
                        chk("upd_mispredict", 32'(b.upd_mispredict), 32'(u.mis));
                        chk("redirect", 32'(b.redirect), 32'(u.mis));
                        chk("upd_choice_inc", 32'(b.upd_choice_inc), 32'(u.inc));
                        chk("upd_choice_dec", 32'(b.upd_choice_dec), 32'(u.dec));
                        chk("mispred_count", 32'(b.mispred_count), 32'(u.mc));
                    end
                end else begin
                    chk("idle_pulses", 32'({b.redirect, b.upd_mispredict, b.upd_choice_inc, b.upd_choice_dec}), 32'h0);
                end
            end
        end
    end
    initial begin : stim
        logic rt;
        n_chk  = 0;
        n_fail = 0;
        mc     = 0;
        rst_n  = 1'b1;
        @(posedge clk);
        do_reset();
        push(32'h100, 1'b1, 1'b1, 1'b0, 12'h0a5);
        pop(1'b1);
        idle();
        for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 12'(i));
        push(32'h2ff, 1'b1, 1'b1, 1'b1, 12'hfff);
        step(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 12'h300, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) pop(1'b1);
        idle();
        push(32'hA, 1'b1, 1'b0, 1'b1, 12'h00a);
        push(32'hB, 1'b0, 1'b0, 1'b0, 12'h00b);
        push(32'hC, 1'b1, 1'b1, 1'b1, 12'h00c);
        step(1'b1, 32'hD, 1'b1, 1'b1, 1'b1, 12'h00d, 1'b1, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(i), 1'b0, 1'b1, 1'b0, 12'(i));
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle();
        for (int i = 0; i < 10; i++) begin
            rt = 1'($urandom);
            push(32'h1000 + 32'(i * 8), rt, 1'($urandom), 1'($urandom), 12'($urandom));
            pop(rt);
        end
        pop(1'b1);
        idle();
        for (int i = 0; i < 5; i++) push(32'h500 + 32'(i), 1'b1, 1'b1, 1'b0, 12'(i));
        idle();
        do_reset();
        idle();
        idle();
        for (int i = 0; i < 400; i++) begin
            rt = (mq.size() != 0) ? (($urandom % 5 == 0) ? !mq[0].t : mq[0].t) : 1'($urandom);
            step(1'($urandom % 3 != 0), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                 12'($urandom), 1'($urandom), rt, 1'($urandom % 40 == 0));
        end
        idle();
        idle();
        chk("scoreboard_drained", 32'(eq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
